hid_report_sniffer: RTL and testbench

- Passive HID boot-keyboard sniffer with transaction tracking.
- Follows USB tokens, captures the keyboard IN report and the LED OUT report.
- Commits a captured report only after a matching ACK handshake.
- Diffs successive keyboard reports into a serial key press/release event stream, buffered in a FIFO with valid/ready handshake. Sits beside the USB packet decoder in the proxy datapath.

---
 rtl/usb_pkg.sv | 31 +++
 rtl/hid_event_fifo.sv | 54 +++++
 rtl/hid_report_sniffer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_hid_report_sniffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB/HID definitions for the report sniffer: PID codes, HID usage
// constants, transaction tracker states and the key event record.
`timescale 1ns/1ps
package usb_pkg;

   localparam logic [7:0] PID_OUT   = 8'hE1;
   localparam logic [7:0] PID_IN    = 8'h69;
   localparam logic [7:0] PID_SETUP = 8'h2D;
   localparam logic [7:0] PID_DATA0 = 8'hC3;
   localparam logic [7:0] PID_DATA1 = 8'h4B;
   localparam logic [7:0] PID_ACK   = 8'hD2;
   localparam logic [7:0] PID_NAK   = 8'h5A;
   localparam logic [7:0] PID_STALL = 8'h1E;

   localparam logic [7:0] HID_MOD_BASE     = 8'hE0;
   localparam logic [7:0] HID_ERR_ROLLOVER = 8'h01;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_IN_TOK,
      ST_OUT_TOK,
      ST_WAIT_ACK_IN,
      ST_WAIT_ACK_OUT
   } txn_state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       press;
   } hid_event_t;

endpackage

// File: rtl/hid_event_fifo.sv
// Event FIFO with valid/ready on both sides. Pointers carry one extra wrap
// bit so full and empty are distinguishable; a push is accepted while full
// when a pop happens in the same cycle. Output data reads as zero when empty.
`timescale 1ns/1ps
module hid_event_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop       = !empty && out_ready;
   assign in_ready  = !full || pop;
   assign push      = in_valid && in_ready;
   assign out_valid = !empty;
   assign out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // Pointer bookkeeping for accepted pushes and pops.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   // Storage write; contents need no reset because empty masks the output.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
   end

endmodule

// File: rtl/hid_report_sniffer.sv
// Passive HID boot-keyboard sniffer. Tracks IN/OUT transactions on the
// keyboard and LED endpoints, commits a report only once its ACK is seen,
// and diffs successive keyboard reports into press/release events.
`timescale 1ns/1ps
module hid_report_sniffer
   import usb_pkg::*;
#(
   parameter int         NKEYS       = 6,
   parameter int         KBD_EP      = 1,
   parameter int         LED_EP      = 0,
   parameter int         MATCH_ADDR  = 0,
   parameter int         EV_DEPTH    = 16,
   parameter int         TIMEOUT_CYC = 1024,
   parameter logic [2:0] PKT_DONE    = 3'd4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [63:0]        data,
   input  logic [3:0]         data_len,
   input  logic [2:0]         usb_state,
   input  logic [7:0]         pid,
   input  logic               host_dir,
   output logic [7:0]         modifier,
   output logic [8*NKEYS-1:0] keycodes,
   output logic [4:0]         leds,
   output logic               ev_valid,
   input  logic               ev_ready,
   output logic [7:0]         ev_code,
   output logic               ev_press,
   output logic               rollover_err,
   output logic               busy
);

   localparam int              TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam int              SCAN_LEN = 8 + 2*NKEYS;
   localparam int              IW       = $clog2(SCAN_LEN);
   localparam logic [IW-1:0]   IDX_LAST = IW'(SCAN_LEN - 1);
   localparam logic [3:0]      KBD_LEN  = 4'(2 + NKEYS);

   txn_state_t         state_q, state_d, tok_next;
   logic [2:0]         usb_state_p1;
   logic [TW-1:0]      tmo_q;
   logic               pkt_evt, addr_ok, is_data, enter;
   logic               latch_kbd, latch_led, commit_kbd, commit_led;
   logic               pend_roll, kbd_commit, roll_hit;
   logic [7:0]         pend_mod_q;
   logic [8*NKEYS-1:0] pend_keys_q;
   logic [4:0]         pend_led_q;
   logic [7:0]         old_mod_q, new_mod_q, shadow_mod_q, sh_mod;
   logic [8*NKEYS-1:0] old_keys_q, new_keys_q, shadow_keys_q, sh_keys;
   logic               shadow_vld_q, sh_vld;
   logic [IW-1:0]      idx_q;
   logic               scan_hit, scan_adv, scan_last, start, restart;
   logic               fifo_in_ready;
   hid_event_t         scan_ev, fifo_out;
   logic               unused_data;

   // Reserved report byte and bytes past the last keycode slot are ignored.
   assign unused_data = ^data;

   assign pkt_evt = (usb_state == PKT_DONE) && (usb_state_p1 != PKT_DONE);
   assign addr_ok = (MATCH_ADDR == 0) || (data[6:0] == 7'(MATCH_ADDR));
   assign is_data = (pid == PID_DATA0) || (pid == PID_DATA1);

   function automatic logic key_in(input logic [8*NKEYS-1:0] keys, input logic [7:0] k);
      key_in = 1'b0;
      for (int i = 0; i < NKEYS; i++) if (keys[8*i +: 8] == k) key_in = 1'b1;
   endfunction

   function automatic logic dup_before(input logic [8*NKEYS-1:0] keys, input int s);
      dup_before = 1'b0;
      for (int i = 0; i < NKEYS; i++)
         if (i < s && keys[8*i +: 8] == keys[8*s +: 8]) dup_before = 1'b1;
   endfunction

   function automatic logic all_rollover(input logic [8*NKEYS-1:0] keys);
      all_rollover = 1'b1;
      for (int i = 0; i < NKEYS; i++)
         if (keys[8*i +: 8] != HID_ERR_ROLLOVER) all_rollover = 1'b0;
   endfunction

   // Transaction state, packet edge detector and handshake timeout counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         usb_state_p1 <= '0;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         usb_state_p1 <= usb_state;
         if (enter)                  tmo_q <= '0;
         else if (state_q != ST_IDLE) tmo_q <= tmo_q + TW'(1);
      end
   end

   // Next transaction state plus latch/commit strobes.
   always_comb begin
      tok_next = ST_IDLE;
      case (pid)
         PID_IN:    if (addr_ok && data[10:7] == 4'(KBD_EP)) tok_next = ST_IN_TOK;
         PID_OUT:   if (addr_ok && data[10:7] == 4'(LED_EP)) tok_next = ST_OUT_TOK;
         PID_SETUP: tok_next = ST_IDLE;
         default:   tok_next = ST_IDLE;
      endcase
      state_d    = state_q;
      latch_kbd  = 1'b0;
      latch_led  = 1'b0;
      commit_kbd = 1'b0;
      commit_led = 1'b0;
      if (pkt_evt) begin
         case (state_q)
            ST_IDLE: state_d = tok_next;
            ST_IN_TOK: begin
               state_d = ST_IDLE;
               if (is_data && !host_dir && data_len >= KBD_LEN) begin
                  latch_kbd = 1'b1;
                  state_d   = ST_WAIT_ACK_IN;
               end
            end
            ST_OUT_TOK: begin
               state_d = ST_IDLE;
               if (is_data && host_dir && data_len == 4'd1) begin
                  latch_led = 1'b1;
                  state_d   = ST_WAIT_ACK_OUT;
               end
            end
            ST_WAIT_ACK_IN, ST_WAIT_ACK_OUT: begin
               if (pid == PID_ACK) begin
                  commit_kbd = (state_q == ST_WAIT_ACK_IN);
                  commit_led = (state_q == ST_WAIT_ACK_OUT);
                  state_d    = ST_IDLE;
               end else if (pid == PID_NAK || pid == PID_STALL) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = tok_next;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE && tmo_q == TMO_LAST) begin
         state_d = ST_IDLE;
      end
      enter = pkt_evt && (state_d != ST_IDLE);
   end

   // Pending report capture from the DATA stage awaiting its handshake.
   always_ff @(posedge clk) begin
      if (latch_kbd) begin
         pend_mod_q  <= data[7:0];
         pend_keys_q <= data[16 +: 8*NKEYS];
      end
      if (latch_led) pend_led_q <= data[4:0];
   end

   assign pend_roll  = all_rollover(pend_keys_q);
   assign kbd_commit = commit_kbd && !pend_roll;
   assign roll_hit   = commit_kbd && pend_roll;

   // Committed report outputs and the rollover error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         modifier     <= '0;
         keycodes     <= '0;
         leds         <= '0;
         rollover_err <= 1'b0;
      end else begin
         rollover_err <= roll_hit;
         if (kbd_commit) begin
            modifier <= pend_mod_q;
            keycodes <= pend_keys_q;
         end
         if (commit_led) leds <= pend_led_q;
      end
   end

   // Evaluate the current scan slot: modifier bits, then releases, then presses.
   always_comb begin
      int         s;
      logic [7:0] k;
      s        = 0;
      k        = '0;
      scan_hit = 1'b0;
      scan_ev  = '0;
      if (idx_q < IW'(8)) begin
         s             = int'(idx_q);
         scan_hit      = old_mod_q[s] != new_mod_q[s];
         scan_ev.code  = HID_MOD_BASE + 8'(idx_q);
         scan_ev.press = new_mod_q[s];
      end else if (idx_q < IW'(8 + NKEYS)) begin
         s             = int'(idx_q) - 8;
         k             = old_keys_q[8*s +: 8];
         scan_hit      = (k != 8'h00) && !key_in(new_keys_q, k) && !dup_before(old_keys_q, s);
         scan_ev.code  = k;
         scan_ev.press = 1'b0;
      end else begin
         s             = int'(idx_q) - 8 - NKEYS;
         k             = new_keys_q[8*s +: 8];
         scan_hit      = (k != 8'h00) && !key_in(old_keys_q, k) && !dup_before(new_keys_q, s);
         scan_ev.code  = k;
         scan_ev.press = 1'b1;
      end
   end

   assign scan_adv  = busy && (!scan_hit || fifo_in_ready);
   assign scan_last = scan_adv && (idx_q == IDX_LAST);
   assign start     = kbd_commit && !busy;
   assign sh_vld    = kbd_commit || shadow_vld_q;
   assign sh_mod    = kbd_commit ? pend_mod_q  : shadow_mod_q;
   assign sh_keys   = kbd_commit ? pend_keys_q : shadow_keys_q;
   assign restart   = scan_last && sh_vld && ({sh_mod, sh_keys} != {new_mod_q, new_keys_q});

   // Diff engine control: scan index, busy flag and the commit-while-busy shadow.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy          <= 1'b0;
         idx_q         <= '0;
         shadow_vld_q  <= 1'b0;
         shadow_mod_q  <= '0;
         shadow_keys_q <= '0;
      end else begin
         if (kbd_commit && busy) begin
            shadow_mod_q  <= pend_mod_q;
            shadow_keys_q <= pend_keys_q;
            shadow_vld_q  <= 1'b1;
         end
         if (start) begin
            busy  <= 1'b1;
            idx_q <= '0;
         end else if (scan_last) begin
            shadow_vld_q <= 1'b0;
            idx_q        <= '0;
            if (!restart) busy <= 1'b0;
         end else if (scan_adv) begin
            idx_q <= idx_q + IW'(1);
         end
      end
   end

   // Diff snapshots: old/new report pair being compared.
   always_ff @(posedge clk) begin
      if (start) begin
         old_mod_q  <= modifier;
         old_keys_q <= keycodes;
         new_mod_q  <= pend_mod_q;
         new_keys_q <= pend_keys_q;
      end else if (restart) begin
         old_mod_q  <= new_mod_q;
         old_keys_q <= new_keys_q;
         new_mod_q  <= sh_mod;
         new_keys_q <= sh_keys;
      end
   end

   hid_event_fifo #(
      .DEPTH (EV_DEPTH),
      .WIDTH ($bits(hid_event_t))
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (busy && scan_hit),
      .in_ready  (fifo_in_ready),
      .in_data   (scan_ev),
      .out_valid (ev_valid),
      .out_ready (ev_ready),
      .out_data  (fifo_out)
   );

   assign ev_code  = fifo_out.code;
   assign ev_press = fifo_out.press;

endmodule

// File: tb/tb_hid_report_sniffer.sv
// Directed bench for hid_report_sniffer: token/data/handshake sequences with
// hand-computed committed reports and event streams.
`timescale 1ns/1ps
module tb_hid_report_sniffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] data = '0;
   logic [3:0]  data_len = '0;
   logic [2:0]  usb_state = '0;
   logic [7:0]  pid = '0;
   logic        host_dir = 1'b0;
   logic [7:0]  modifier;
   logic [47:0] keycodes;
   logic [4:0]  leds;
   logic        ev_valid;
   logic        ev_ready = 1'b0;
   logic [7:0]  ev_code;
   logic        ev_press;
   logic        rollover_err;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [7:0] P_OUT = 8'hE1, P_IN = 8'h69, P_D0 = 8'hC3, P_D1 = 8'h4B;
   localparam logic [7:0] P_ACK = 8'hD2, P_NAK = 8'h5A;

   always #5 clk = ~clk;

   hid_report_sniffer dut (
      .clk          (clk),
      .rst          (rst),
      .data         (data),
      .data_len     (data_len),
      .usb_state    (usb_state),
      .pid          (pid),
      .host_dir     (host_dir),
      .modifier     (modifier),
      .keycodes     (keycodes),
      .leds         (leds),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .ev_code      (ev_code),
      .ev_press     (ev_press),
      .rollover_err (rollover_err),
      .busy         (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One packet: PKT_DONE held for 'hold' cycles, then one idle cycle.
   task automatic pkt(input logic [7:0] p, input logic [63:0] d, input logic [3:0] len,
                      input logic dir, input int hold);
      pid = p; data = d; data_len = len; host_dir = dir; usb_state = 3'd4;
      tick(hold);
      usb_state = 3'd0;
      tick(1);
   endtask

   function automatic logic [63:0] kbd(input logic [7:0] m, input logic [47:0] k);
      return {k, 8'h00, m};
   endfunction

   task automatic expect_ev(input string tag, input logic [7:0] code, input logic press);
      int n = 0;
      while (ev_valid !== 1'b1 && n < 200) begin
         tick(1);
         n++;
      end
      chk({tag, " valid"}, 64'(ev_valid), 64'(1'b1));
      chk({tag, " code"},  64'(ev_code),  64'(code));
      chk({tag, " press"}, 64'(ev_press), 64'(press));
      ev_ready = 1'b1;
      tick(1);
      ev_ready = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 500) begin
         tick(1);
         n++;
      end
      chk({tag, " busy"},  64'(busy), 64'(1'b0));
      chk({tag, " evq"},   64'(ev_valid), 64'(1'b0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset state
      tick(3);
      chk("rst modifier", 64'(modifier), 64'h0);
      chk("rst keycodes", 64'(keycodes), 64'h0);
      chk("rst leds",     64'(leds),     64'h0);
      chk("rst ev_valid", 64'(ev_valid), 64'h0);
      chk("rst ev_code",  64'(ev_code),  64'h0);
      chk("rst ev_press", 64'(ev_press), 64'h0);
      chk("rst rollover", 64'(rollover_err), 64'h0);
      chk("rst busy",     64'(busy),     64'h0);
      rst = 1'b0;
      tick(2);

      // First report: mod 02, key 04
      pkt(P_IN,  64'h85, 4'd0, 1'b1, 1);
      pkt(P_D1,  kbd(8'h02, 48'h04), 4'd8, 1'b0, 1);
      pkt(P_ACK, 64'h0, 4'd0, 1'b1, 1);
      chk("r1 modifier", 64'(modifier), 64'h02);
      chk("r1 keycodes", 64'(keycodes), 64'h04);
      chk("r1 busy",     64'(busy),     64'h1);
      expect_ev("r1 e0", 8'hE1, 1'b1);
      expect_ev("r1 e1", 8'h04, 1'b1);
      wait_idle("r1");

      // Second report: mod 00, key 05; DATA held several cycles (one event only)
      pkt(P_IN,  64'h85, 4'd0, 1'b1, 1);
      pkt(P_D0,  kbd(8'h00, 48'h05), 4'd8, 1'b0, 3);
      pkt(P_ACK, 64'h0, 4'd0, 1'b1, 1);
      chk("r2 modifier", 64'(modifier), 64'h00);
      chk("r2 keycodes", 64'(keycodes), 64'h05);
      expect_ev("r2 e0", 8'hE1, 1'b0);
      expect_ev("r2 e1", 8'h04, 1'b0);
      expect_ev("r2 e2", 8'h05, 1'b1);
      wait_idle("r2");

      // NAK discards the pending report
      pkt(P_IN,  64'h85, 4'd0, 1'b1, 1);
      pkt(P_D0,  kbd(8'h00, 48'h06), 4'd8, 1'b0, 1);
      pkt(P_NAK, 64'h0, 4'd0, 1'b0, 1);
      tick(30);
      chk("nak keycodes", 64'(keycodes), 64'h05);
      chk("nak busy",     64'(busy),     64'h0);
      chk("nak ev_valid", 64'(ev_valid), 64'h0);

      // Handshake timeout: late ACK must not commit
      pkt(P_IN,  64'h85, 4'd0, 1'b1, 1);
      pkt(P_D0,  kbd(8'h00, 48'h06), 4'd8, 1'b0, 1);
      tick(1100);
      pkt(P_ACK, 64'h0, 4'd0, 1'b1, 1);
      tick(5);
      chk("tmo keycodes", 64'(keycodes), 64'h05);
      chk("tmo busy",     64'(busy),     64'h0);
      chk("tmo ev_valid", 64'(ev_valid), 64'h0);

      // LED report, then a zero-length status stage that must not commit
      pkt(P_OUT, 64'h05, 4'd0, 1'b1, 1);
      pkt(P_D0,  64'h02, 4'd1, 1'b1, 1);
      pkt(P_ACK, 64'h0,  4'd0, 1'b0, 1);
      chk("led commit", 64'(leds), 64'h02);
      pkt(P_OUT, 64'h05, 4'd0, 1'b1, 1);
      pkt(P_D0,  64'h1F, 4'd0, 1'b1, 1);
      pkt(P_ACK, 64'h0,  4'd0, 1'b0, 1);
      tick(3);
      chk("led zlp", 64'(leds), 64'h02);
      chk("led keycodes", 64'(keycodes), 64'h05);

      // Three back-to-back reports with the consumer stalled
      pkt(P_IN,  64'h85, 4'd0, 1'b1, 1);
      pkt(P_D1,  kbd(8'h00, 48'h151413121110), 4'd8, 1'b0, 1);
      pkt(P_ACK, 64'h0, 4'd0, 1'b1, 1);
      pkt(P_IN,  64'h85, 4'd0, 1'b1, 1);
      pkt(P_D0,  kbd(8'h00, 48'h252423222120), 4'd8, 1'b0, 1);
      pkt(P_ACK, 64'h0, 4'd0, 1'b1, 1);
      pkt(P_IN,  64'h85, 4'd0, 1'b1, 1);
      pkt(P_D1,  kbd(8'h00, 48'h353433323130), 4'd8, 1'b0, 1);
      pkt(P_ACK, 64'h0, 4'd0, 1'b1, 1);
      tick(60);
      chk("ov keycodes", 64'(keycodes), 64'h353433323130);
      chk("ov busy",     64'(busy),     64'h1);
      chk("ov ev_valid", 64'(ev_valid), 64'h1);
      expect_ev("ov rel05", 8'h05, 1'b0);
      for (int i = 0; i < 6; i++) expect_ev("ov pressA", 8'(8'h10 + i), 1'b1);
      for (int i = 0; i < 6; i++) expect_ev("ov relA",   8'(8'h10 + i), 1'b0);
      for (int i = 0; i < 6; i++) expect_ev("ov pressC", 8'(8'h30 + i), 1'b1);
      wait_idle("ov");
      chk("ov final keycodes", 64'(keycodes), 64'h353433323130);

      // ErrorRollOver report: pulse only, nothing committed
      pkt(P_IN, 64'h85, 4'd0, 1'b1, 1);
      pkt(P_D0, kbd(8'h00, 48'h010101010101), 4'd8, 1'b0, 1);
      pid = P_ACK; data = '0; data_len = '0; host_dir = 1'b1; usb_state = 3'd4;
      tick(1);
      chk("roll pulse", 64'(rollover_err), 64'h1);
      usb_state = 3'd0;
      tick(1);
      chk("roll end",      64'(rollover_err), 64'h0);
      chk("roll keycodes", 64'(keycodes), 64'h353433323130);
      tick(30);
      chk("roll busy",     64'(busy),     64'h0);
      chk("roll ev_valid", 64'(ev_valid), 64'h0);

      // Reset while waiting for the IN handshake
      pkt(P_IN, 64'h85, 4'd0, 1'b1, 1);
      pkt(P_D0, kbd(8'h00, 48'h07), 4'd8, 1'b0, 1);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      pkt(P_ACK, 64'h0, 4'd0, 1'b1, 1);
      tick(3);
      chk("rstw keycodes", 64'(keycodes), 64'h0);
      chk("rstw modifier", 64'(modifier), 64'h0);
      chk("rstw leds",     64'(leds),     64'h0);
      chk("rstw busy",     64'(busy),     64'h0);
      chk("rstw ev_valid", 64'(ev_valid), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
